// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - sequential register-file dump with valid/ready output and abort
module regfile_dump_reader #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [AW-1:0]   first_addr,
    input  logic [AW-1:0]   last_addr,
    output logic [AW-1:0]   rf_addr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   out_addr,
    output logic [XLEN-1:0] out_data,
    output logic            busy,
    output logic            done,
    output logic [AW:0]     count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Beat count tops out at the number of registers in the file.
    localparam logic [AW:0]   COUNT_MAX = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   COUNT_ONE = 1;
    localparam logic [AW-1:0] ADDR_ONE  = 1;

    state_t        state;
    state_t        state_d;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] last_q;

    logic load;       // accept a start: latch range, clear count
    logic capture;    // register the addressed word into the output beat
    logic accept;     // consumer took the beat this cycle
    logic advance;    // step to the next register
    logic valid_clr;  // retire the output beat (accepted or abandoned)

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and control decode; abort always returns to IDLE from an active state.
    always_comb begin
        state_d   = state;
        load      = 1'b0;
        capture   = 1'b0;
        accept    = 1'b0;
        advance   = 1'b0;
        valid_clr = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    load    = 1'b1;
                    state_d = (first_addr <= last_addr) ? S_READ : S_DONE;
                end
            end
            S_READ: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    capture = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    // A beat handed over together with abort still counts.
                    accept    = 1'b1;
                    valid_clr = 1'b1;
                    if (abort) begin
                        state_d = S_IDLE;
                    end else if (addr_q == last_q) begin
                        // Compare before incrementing so a range ending at the
                        // top register never wraps the counter to zero.
                        state_d = S_DONE;
                    end else begin
                        advance = 1'b1;
                        state_d = S_READ;
                    end
                end else if (abort) begin
                    valid_clr = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Address counter and latched end of range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            last_q <= '0;
        end else if (load) begin
            addr_q <= first_addr;
            last_q <= last_addr;
        end else if (advance) begin
            addr_q <= addr_q + ADDR_ONE;
        end
    end

    // Output beat: captured in READ, held through HOLD until taken or abandoned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_addr  <= addr_q;
            // Register x0 is hardwired to zero regardless of what the file returns.
            out_data  <= (addr_q == '0) ? '0 : rf_rdata;
        end else if (valid_clr) begin
            out_valid <= 1'b0;
        end
    end

    // Accepted-beat counter, cleared on each accepted start and saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (accept && (count != COUNT_MAX)) begin
            count <= count + COUNT_ONE;
        end
    end

    assign rf_addr = addr_q;
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE) && !abort;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - directed self-checking bench for regfile_dump_reader
module tb_regfile_dump_reader;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            abort;
    logic [AW-1:0]   first_addr;
    logic [AW-1:0]   last_addr;
    logic [AW-1:0]   rf_addr;
    logic [XLEN-1:0] rf_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [AW-1:0]   out_addr;
    logic [XLEN-1:0] out_data;
    logic            busy;
    logic            done;
    logic [AW:0]     count;

    int errors = 0;
    int checks = 0;

    int nbeats = 0;
    int ndone  = 0;
    logic [AW-1:0]   mon_addr [0:255];
    logic [XLEN-1:0] mon_data [0:255];

    regfile_dump_reader #(.XLEN(XLEN), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rf_addr    (rf_addr),
        .rf_rdata   (rf_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .count      (count)
    );

    always #5 clk = ~clk;

    // Register file model: register k holds 4*k.
    assign rf_rdata = {{(XLEN-AW-2){1'b0}}, rf_addr, 2'b00};

    // Record handshakes and done pulses between edges.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && nbeats < 256) begin
            mon_addr[nbeats] <= out_addr;
            mon_data[nbeats] <= out_data;
            nbeats           <= nbeats + 1;
        end
        if (done) begin
            ndone <= ndone + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int b0;
        int d0;
        int n;

        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        out_ready  = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_rf_addr",   rf_addr,   0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_addr",  out_addr,  0);
        check("rst_out_data",  out_data,  0);
        check("rst_busy",      busy,      0);
        check("rst_done",      done,      0);
        check("rst_count",     count,     0);

        // Full dump 0..31, start on the very first edge after release
        b0 = nbeats; d0 = ndone;
        rst_n = 1'b1; first_addr = 5'd0; last_addr = 5'd31; out_ready = 1'b1; start = 1'b1;
        tick();
        check("full_busy",     busy,      1);
        check("full_read_vld", out_valid, 0);
        check("full_rf_addr0", rf_addr,   0);
        start = 1'b0;
        tick();
        check("full_latency_vld", out_valid, 1);
        check("full_beat0_addr",  out_addr,  0);
        check("full_beat0_data",  out_data,  0);
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check("full_cycles",   n,       63);
        check("full_done",     done,    1);
        check("full_no_wrap",  rf_addr, 31);
        tick();
        check("full_done_end", done,    0);
        check("full_idle",     busy,    0);
        check("full_count",    count,   32);
        check("full_rf_hold",  rf_addr, 31);
        check("full_nbeats",   nbeats - b0, 32);
        check("full_ndone",    ndone - d0,  1);
        for (int k = 0; k < 32; k++) begin
            check("full_beat_addr", mon_addr[b0+k], k);
            check("full_beat_data", mon_data[b0+k], 4*k);
        end

        // Backpressure: 3..5, ready low while beat 4 is held
        b0 = nbeats;
        first_addr = 5'd3; last_addr = 5'd5; out_ready = 1'b1; start = 1'b1;
        tick();
        check("bp_count_clr", count, 0);
        start = 1'b0;
        tick();
        check("bp_beat3_addr", out_addr, 3);
        check("bp_beat3_data", out_data, 12);
        tick();
        check("bp_count1", count, 1);
        out_ready = 1'b0;
        tick();
        check("bp_beat4_vld",  out_valid, 1);
        check("bp_beat4_addr", out_addr,  4);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("bp_hold_vld",  out_valid, 1);
            check("bp_hold_addr", out_addr,  4);
            check("bp_hold_data", out_data,  16);
            check("bp_hold_cnt",  count,     1);
        end
        out_ready = 1'b1;
        tick();
        check("bp_read5_vld", out_valid, 0);
        check("bp_count2",    count,     2);
        tick();
        check("bp_beat5_addr", out_addr, 5);
        check("bp_beat5_data", out_data, 20);
        tick();
        check("bp_done",  done,  1);
        check("bp_count", count, 3);
        tick();
        check("bp_done_end", done, 0);
        check("bp_idle",     busy, 0);
        check("bp_nbeats",   nbeats - b0, 3);

        // Empty range: first > last
        b0 = nbeats;
        first_addr = 5'd7; last_addr = 5'd2; start = 1'b1;
        tick();
        check("empty_done",    done,      1);
        check("empty_busy",    busy,      1);
        check("empty_vld",     out_valid, 0);
        check("empty_rf_addr", rf_addr,   7);
        check("empty_count",   count,     0);
        start = 1'b0;
        tick();
        check("empty_done_end", done, 0);
        check("empty_idle",     busy, 0);
        check("empty_nbeats",   nbeats - b0, 0);

        // Abort together with ready on beat 4 of 1..10
        b0 = nbeats; d0 = ndone;
        first_addr = 5'd1; last_addr = 5'd10; out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(out_valid && out_addr == 5'd4) && n < 50) begin
            tick();
            n++;
        end
        check("abort_found_beat4", out_addr, 4);
        abort = 1'b1;
        tick();
        check("abort_idle",  busy,      0);
        check("abort_vld",   out_valid, 0);
        check("abort_count", count,     4);
        check("abort_done",  done,      0);
        abort = 1'b0;
        tick();
        check("abort_no_done", ndone - d0,  0);
        check("abort_nbeats",  nbeats - b0, 4);

        // Abort and start together in IDLE: start ignored
        abort = 1'b1; start = 1'b1; first_addr = 5'd0; last_addr = 5'd3;
        tick();
        check("idle_abort_busy",  busy,  0);
        check("idle_abort_count", count, 4);
        abort = 1'b0; start = 1'b0;

        // Start while busy is ignored
        b0 = nbeats;
        first_addr = 5'd2; last_addr = 5'd4; out_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("sb_beat2_addr", out_addr, 2);
        first_addr = 5'd20; last_addr = 5'd25; start = 1'b1;
        tick();
        check("sb_busy",     busy,     1);
        check("sb_hold",     out_addr, 2);
        check("sb_rf_addr",  rf_addr,  2);
        start = 1'b0; out_ready = 1'b1;
        n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        check("sb_done",    done,    1);
        check("sb_count",   count,   3);
        check("sb_rf_last", rf_addr, 4);
        tick();
        check("sb_nbeats", nbeats - b0, 3);
        for (int k = 0; k < 3; k++) begin
            check("sb_beat_addr", mon_addr[b0+k], 2 + k);
        end

        // Reset during HOLD, then a single-register dump
        first_addr = 5'd3; last_addr = 5'd5; out_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("rm_pre_addr", out_addr, 3);
        check("rm_pre_data", out_data, 12);
        d0 = ndone;
        rst_n = 1'b0;
        #1;
        check("rm_vld",     out_valid, 0);
        check("rm_addr",    out_addr,  0);
        check("rm_data",    out_data,  0);
        check("rm_busy",    busy,      0);
        check("rm_count",   count,     0);
        check("rm_rf_addr", rf_addr,   0);
        check("rm_done",    done,      0);
        tick();
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        first_addr = 5'd9; last_addr = 5'd9; start = 1'b1;
        tick();
        check("rm_rf_addr9", rf_addr, 9);
        start = 1'b0;
        tick();
        check("rm_beat_vld",  out_valid, 1);
        check("rm_beat_addr", out_addr,  9);
        check("rm_beat_data", out_data,  36);
        tick();
        check("rm_done9",  done,  1);
        check("rm_count9", count, 1);
        tick();
        check("rm_idle",  busy,       0);
        check("rm_ndone", ndone - d0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
REGFILE_DUMP_READER -- requirements
Module: regfile_dump_reader

Interface
REQ-001 Parameter XLEN, default 32, register data width.
REQ-002 Parameter AW, default 5, register address width (2**AW registers).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  dump request; sampled only in IDLE.
REQ-006 abort  input  1  terminate an in-progress dump.
REQ-007 first_addr  input  AW  first register to read, latched on accepted start.
REQ-008 last_addr  input  AW  last register to read, latched on accepted start.
REQ-009 rf_addr  output  AW  read address to the register file.
REQ-010 rf_rdata  input  XLEN  combinational read data for rf_addr, valid in the same cycle.
REQ-011 out_valid  output  1  out_addr/out_data hold a beat.
REQ-012 out_ready  input  1  consumer accepts the beat.
REQ-013 out_addr  output  AW  register index of the current beat.
REQ-014 out_data  output  XLEN  register contents of the current beat.
REQ-015 busy  output  1  high in READ, HOLD and DONE.
REQ-016 done  output  1  one-cycle pulse on normal completion.
REQ-017 count  output  AW+1  beats accepted since last accepted start.

Function
REQ-018 FSM states: IDLE, READ, HOLD, DONE.
REQ-019 IDLE: start=1 latches first/last, clears count, loads address counter with first_addr; next state READ if first_addr<=last_addr, else DONE (zero beats).
REQ-020 start outside IDLE is ignored.
REQ-021 rf_addr equals the address counter at all times (0 after reset).
REQ-022 READ: registers out_addr=counter, out_data=rf_rdata (forced to 0 when counter=0, x0 hardwired), out_valid=1; next state HOLD.
REQ-023 HOLD: out_addr, out_data, out_valid stable while out_ready=0.
REQ-024 HOLD with out_ready=1: beat accepted, count increments, out_valid=0 next cycle; next state DONE if counter=last, else counter+1 and READ.
REQ-025 Counter never wraps: when last_addr=2**AW-1, completion is detected by compare before increment.
REQ-026 Latency: start at cycle N -> out_valid high at cycle N+2; throughput one beat per 2 cycles with out_ready held high.
REQ-027 DONE: done=1 for exactly one cycle, next state IDLE.
REQ-028 abort=1 in READ, HOLD or DONE: next state IDLE, out_valid=0, no done pulse; count retains beats already accepted.
REQ-029 abort and out_ready both high in HOLD: the beat counts as accepted (count increments), then IDLE; abort wins over advancing.
REQ-030 abort in IDLE has no effect; abort and start both high in IDLE: start ignored.
REQ-031 count saturates at 2**AW (cannot exceed; width AW+1 suffices).

Reset
REQ-032 rst_n=0 forces immediately (asynchronously) state IDLE, counter 0, rf_addr 0, out_valid 0, out_addr 0, out_data 0, busy 0, done 0, count 0.
REQ-033 Reset asserted mid-dump discards the dump; no done pulse after release.
REQ-034 After rst_n deasserts, first start is accepted on the first rising edge with rst_n=1.

Verification
REQ-035 Full dump: first=0,last=31, out_ready=1, rf_rdata=addr*4 -> 32 beats, beat 0 data 0, beat k data 4k, done once, count=32, no wrap to address 0.
REQ-036 Backpressure: first=3,last=5, out_ready low 4 cycles on beat 4 -> out_addr=4/out_data stable throughout, then beat 5, count=3.
REQ-037 Empty range: first=7,last=2 -> no out_valid, done one cycle after start accepted, count=0.
REQ-038 Abort: first=1,last=10, abort asserted with out_ready in HOLD of beat 4 -> count=4, IDLE next cycle, no done pulse.
REQ-039 Reset mid-op: rst_n low during HOLD -> all outputs 0 same cycle, after release start with first=last=9 yields single beat addr 9.
REQ-040 Start while busy: second start pulse during HOLD ignored -> original range completes unchanged.
